// File: rtl/tracker_pkg.sv
// Shared constants, state encoding and phase tables for the tracker stepper driver.
// Define TRACKER_HALF_STEP_EN to select the 8-entry half-step sequence.
package tracker_pkg;

    localparam logic [1:0] SPD_NONE = 2'b00;
    localparam logic [1:0] SPD_SLOW = 2'b01;
    localparam logic [1:0] SPD_FAST = 2'b10;
    localparam logic [1:0] SPD_ILL  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN_POS = 2'd1,
        ST_RUN_NEG = 2'd2,
        ST_HOLD    = 2'd3
    } axis_state_e;

`ifdef TRACKER_HALF_STEP_EN
    localparam int IDX_W = 3;
    localparam logic [31:0] PHASE_TBL = {
        4'b1001, 4'b1000, 4'b1100, 4'b0100,
        4'b0110, 4'b0010, 4'b0011, 4'b0001
    };
`else
    localparam int IDX_W = 2;
    localparam logic [15:0] PHASE_TBL = {
        4'b1001, 4'b1100, 4'b0110, 4'b0011
    };
`endif

    function automatic logic [3:0] phase_pattern(input logic [IDX_W-1:0] idx);
        return PHASE_TBL[{idx, 2'b00} +: 4];
    endfunction

endpackage

// File: rtl/stepper_axis.sv
// One stepper axis: command decode, run/hold FSM, step divider,
// phase index, absolute position and soft-limit tracking.
module stepper_axis
    import tracker_pkg::*;
#(
    parameter int SLOW_DIV    = 50000,
    parameter int FAST_DIV    = 12500,
    parameter int DEAD_CYCLES = 25000,
    parameter int POS_W       = 16,
    parameter int MAX         = 180
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             home_clr,
    input  logic [1:0]       cmd_pos,
    input  logic [1:0]       cmd_neg,
    output logic [3:0]       coil,
    output logic [POS_W-1:0] pos,
    output logic             busy,
    output logic             at_limit,
    output logic             fault
);

    localparam int DIV_TOP = (SLOW_DIV > FAST_DIV) ? SLOW_DIV : FAST_DIV;
    localparam int CNT_TOP = (DIV_TOP > DEAD_CYCLES) ? DIV_TOP : DEAD_CYCLES;
    localparam int CNT_W   = $clog2(CNT_TOP + 1);

    localparam logic [CNT_W-1:0] SLOW_M1 = CNT_W'(SLOW_DIV - 1);
    localparam logic [CNT_W-1:0] FAST_M1 = CNT_W'(FAST_DIV - 1);
    localparam logic [CNT_W-1:0] DEAD_M1 = CNT_W'(DEAD_CYCLES - 1);
    localparam logic [POS_W-1:0] MAX_P   = POS_W'(MAX);

    axis_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [POS_W-1:0] pos_q, pos_d;
    logic             lim_q, lim_d;
    logic             fault_q, fault_d;
    logic [3:0]       coil_q, coil_d;

    logic             conflict;
    logic             bad_code;
    logic             want_pos;
    logic             want_neg;
    logic [1:0]       spd;
    logic [CNT_W-1:0] div_m1;
    logic             tick;
    logic             step_en;

    // Conflicting or illegal codes behave as "no command" but latch fault.
    always_comb begin
        conflict = (cmd_pos != SPD_NONE) && (cmd_neg != SPD_NONE);
        bad_code = conflict || (cmd_pos == SPD_ILL) || (cmd_neg == SPD_ILL);
        want_pos = !conflict && ((cmd_pos == SPD_SLOW) || (cmd_pos == SPD_FAST));
        want_neg = !conflict && ((cmd_neg == SPD_SLOW) || (cmd_neg == SPD_FAST));
        spd      = want_pos ? cmd_pos : cmd_neg;
        div_m1   = (spd == SPD_FAST) ? FAST_M1 : SLOW_M1;
        // ">=" lets a mid-run speed-up tick on the very next cycle.
        tick     = (cnt_q >= div_m1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            pos_q   <= '0;
            lim_q   <= 1'b0;
            fault_q <= 1'b0;
            coil_q  <= 4'b0000;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            pos_q   <= pos_d;
            lim_q   <= lim_d;
            fault_q <= fault_d;
            coil_q  <= coil_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        step_en = 1'b0;
        if (!enable) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    cnt_d = '0;
                    if (want_pos) begin
                        state_d = ST_RUN_POS;
                    end else if (want_neg) begin
                        state_d = ST_RUN_NEG;
                    end
                end
                ST_RUN_POS: begin
                    if (want_pos) begin
                        step_en = tick;
                        cnt_d   = tick ? '0 : cnt_q + 1'b1;
                    end else begin
                        state_d = want_neg ? ST_HOLD : ST_IDLE;
                        cnt_d   = '0;
                    end
                end
                ST_RUN_NEG: begin
                    if (want_neg) begin
                        step_en = tick;
                        cnt_d   = tick ? '0 : cnt_q + 1'b1;
                    end else begin
                        state_d = want_pos ? ST_HOLD : ST_IDLE;
                        cnt_d   = '0;
                    end
                end
                ST_HOLD: begin
                    if (cnt_q == DEAD_M1) begin
                        cnt_d = '0;
                        if (want_pos) begin
                            state_d = ST_RUN_POS;
                        end else if (want_neg) begin
                            state_d = ST_RUN_NEG;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_comb begin
        pos_d   = pos_q;
        idx_d   = idx_q;
        lim_d   = lim_q;
        fault_d = fault_q | bad_code;
        if (step_en) begin
            if (state_q == ST_RUN_POS) begin
                if (pos_q == MAX_P) begin
                    lim_d = 1'b1;
                end else begin
                    pos_d = pos_q + 1'b1;
                    idx_d = idx_q + 1'b1;
                    lim_d = 1'b0;
                end
            end else begin
                if (pos_q == '0) begin
                    lim_d = 1'b1;
                end else begin
                    pos_d = pos_q - 1'b1;
                    idx_d = idx_q - 1'b1;
                    lim_d = 1'b0;
                end
            end
        end
        if (home_clr) begin
            pos_d = '0;
        end
    end

    always_comb begin
        busy     = (state_q != ST_IDLE);
        coil_d   = enable ? phase_pattern(idx_d) : 4'b0000;
        coil     = coil_q;
        pos      = pos_q;
        at_limit = lim_q;
        fault    = fault_q;
    end

endmodule

// File: rtl/tracker_stepper_driver.sv
// Two-axis stepper driver (theta = elevation, phi = azimuth) behind the tracker.
// TRACKER_HALF_STEP_EN switches both axes to half-step sequencing.
module tracker_stepper_driver
    import tracker_pkg::*;
#(
    parameter int SLOW_DIV    = 50000,
    parameter int FAST_DIV    = 12500,
    parameter int DEAD_CYCLES = 25000,
    parameter int POS_W       = 16,
    parameter int THETA_MAX   = 180,
    parameter int PHI_MAX     = 360
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             home,
    input  logic [1:0]       s_in_theta_pos,
    input  logic [1:0]       s_in_theta_neg,
    input  logic [1:0]       s_in_phi_pos,
    input  logic [1:0]       s_in_phi_neg,
    output logic [3:0]       coil_theta,
    output logic [3:0]       coil_phi,
    output logic [POS_W-1:0] theta_pos,
    output logic [POS_W-1:0] phi_pos,
    output logic [1:0]       busy,
    output logic [1:0]       at_limit,
    output logic             fault
);

    logic busy_t, busy_p;
    logic lim_t, lim_p;
    logic fault_t, fault_p;
    logic home_clr;

    // Homing only makes sense with both motors parked.
    assign home_clr = home && !busy_t && !busy_p;

    stepper_axis #(
        .SLOW_DIV    (SLOW_DIV),
        .FAST_DIV    (FAST_DIV),
        .DEAD_CYCLES (DEAD_CYCLES),
        .POS_W       (POS_W),
        .MAX         (THETA_MAX)
    ) u_theta (
        .clk      (clk),
        .rst      (rst),
        .enable   (enable),
        .home_clr (home_clr),
        .cmd_pos  (s_in_theta_pos),
        .cmd_neg  (s_in_theta_neg),
        .coil     (coil_theta),
        .pos      (theta_pos),
        .busy     (busy_t),
        .at_limit (lim_t),
        .fault    (fault_t)
    );

    stepper_axis #(
        .SLOW_DIV    (SLOW_DIV),
        .FAST_DIV    (FAST_DIV),
        .DEAD_CYCLES (DEAD_CYCLES),
        .POS_W       (POS_W),
        .MAX         (PHI_MAX)
    ) u_phi (
        .clk      (clk),
        .rst      (rst),
        .enable   (enable),
        .home_clr (home_clr),
        .cmd_pos  (s_in_phi_pos),
        .cmd_neg  (s_in_phi_neg),
        .coil     (coil_phi),
        .pos      (phi_pos),
        .busy     (busy_p),
        .at_limit (lim_p),
        .fault    (fault_p)
    );

    assign busy     = {busy_p, busy_t};
    assign at_limit = {lim_p, lim_t};
    assign fault    = fault_t | fault_p;

endmodule

// File: tb/tb_tracker_stepper_driver.sv
// Bench for tracker_stepper_driver: directed scenarios plus random commands,
// all checked against a behavioural per-axis model.
module tb_tracker_stepper_driver;

    localparam int SLOW_DIV    = 8;
    localparam int FAST_DIV    = 2;
    localparam int DEAD_CYCLES = 4;
    localparam int POS_W       = 16;
    localparam int THETA_MAX   = 5;
    localparam int PHI_MAX     = 7;

`ifdef TRACKER_HALF_STEP_EN
    localparam int NPH = 8;
    localparam logic [3:0] PAT [8] = '{4'b0001, 4'b0011, 4'b0010, 4'b0110,
                                       4'b0100, 4'b1100, 4'b1000, 4'b1001};
`else
    localparam int NPH = 4;
    localparam logic [3:0] PAT [4] = '{4'b0011, 4'b0110, 4'b1100, 4'b1001};
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             enable;
    logic             home;
    logic [1:0]       tp, tn, pp, pn;
    logic [3:0]       coil_theta, coil_phi;
    logic [POS_W-1:0] theta_pos, phi_pos;
    logic [1:0]       busy, at_limit;
    logic             fault;
    logic [44:0]      dut_vec;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: mode 0 idle, +1 run pos, -1 run neg, 2 hold.
    int m_mode [2];
    int m_age  [2];
    int m_pos  [2];
    int m_idx  [2];
    bit m_lim  [2];
    bit m_fault;
    bit m_en;

    always #5 clk = ~clk;

    tracker_stepper_driver #(
        .SLOW_DIV    (SLOW_DIV),
        .FAST_DIV    (FAST_DIV),
        .DEAD_CYCLES (DEAD_CYCLES),
        .POS_W       (POS_W),
        .THETA_MAX   (THETA_MAX),
        .PHI_MAX     (PHI_MAX)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .enable         (enable),
        .home           (home),
        .s_in_theta_pos (tp),
        .s_in_theta_neg (tn),
        .s_in_phi_pos   (pp),
        .s_in_phi_neg   (pn),
        .coil_theta     (coil_theta),
        .coil_phi       (coil_phi),
        .theta_pos      (theta_pos),
        .phi_pos        (phi_pos),
        .busy           (busy),
        .at_limit       (at_limit),
        .fault          (fault)
    );

    assign dut_vec = {coil_theta, coil_phi, theta_pos, phi_pos, busy, at_limit, fault};

    task automatic model_reset();
        for (int a = 0; a < 2; a++) begin
            m_mode[a] = 0;
            m_age[a]  = 0;
            m_pos[a]  = 0;
            m_idx[a]  = 0;
            m_lim[a]  = 1'b0;
        end
        m_fault = 1'b0;
        m_en    = 1'b0;
    endtask

    task automatic model_edge();
        int pc [2];
        int nc [2];
        int mx [2];
        bit home_ok;
        pc[0] = int'(tp);
        pc[1] = int'(pp);
        nc[0] = int'(tn);
        nc[1] = int'(pn);
        mx[0] = THETA_MAX;
        mx[1] = PHI_MAX;
        home_ok = home && (m_mode[0] == 0) && (m_mode[1] == 0);
        for (int a = 0; a < 2; a++) begin
            int dir;
            int div;
            int tgt;
            bit clash;
            clash = (pc[a] != 0) && (nc[a] != 0);
            if (clash || pc[a] == 3 || nc[a] == 3) m_fault = 1'b1;
            dir = 0;
            div = SLOW_DIV;
            if (!clash && (pc[a] == 1 || pc[a] == 2)) begin
                dir = 1;
                div = (pc[a] == 1) ? SLOW_DIV : FAST_DIV;
            end else if (!clash && (nc[a] == 1 || nc[a] == 2)) begin
                dir = -1;
                div = (nc[a] == 1) ? SLOW_DIV : FAST_DIV;
            end
            if (!enable) begin
                m_mode[a] = 0;
                m_age[a]  = 0;
            end else if (m_mode[a] == 0) begin
                m_mode[a] = dir;
                m_age[a]  = 0;
            end else if (m_mode[a] == 2) begin
                m_age[a]++;
                if (m_age[a] == DEAD_CYCLES) begin
                    m_mode[a] = dir;
                    m_age[a]  = 0;
                end
            end else if (dir == m_mode[a]) begin
                if (m_age[a] + 1 >= div) begin
                    m_age[a] = 0;
                    tgt = m_pos[a] + dir;
                    if (tgt < 0 || tgt > mx[a]) begin
                        m_lim[a] = 1'b1;
                    end else begin
                        m_pos[a] = tgt;
                        m_idx[a] = (m_idx[a] + dir + NPH) % NPH;
                        m_lim[a] = 1'b0;
                    end
                end else begin
                    m_age[a]++;
                end
            end else begin
                m_mode[a] = (dir == 0) ? 0 : 2;
                m_age[a]  = 0;
            end
            if (home_ok) m_pos[a] = 0;
        end
        m_en = enable;
    endtask

    function automatic logic [44:0] exp_vec();
        logic [3:0] ct;
        logic [3:0] cp;
        logic [1:0] b;
        logic [1:0] l;
        ct = m_en ? PAT[m_idx[0]] : 4'b0000;
        cp = m_en ? PAT[m_idx[1]] : 4'b0000;
        b  = {m_mode[1] != 0, m_mode[0] != 0};
        l  = {m_lim[1], m_lim[0]};
        return {ct, cp, POS_W'(m_pos[0]), POS_W'(m_pos[1]), b, l, m_fault};
    endfunction

    task automatic cyc();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic do_reset();
        #2;
        rst = 1'b0;
        model_reset();
        @(posedge clk);
        #3;
        rst = 1'b1;
    endtask

    task automatic test_reset();
        #1;
        n_checks++;
        if (dut_vec !== 45'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h want 0", dut_vec);
        end
        #2;
        rst = 1'b1;
        cyc();
        n_checks++;
        if (dut_vec !== exp_vec()) begin
            n_fail++;
            $display("FAIL reset_idle: got %h want %h", dut_vec, exp_vec());
        end
    endtask

    task automatic test_first_step();
        enable = 1'b1;
        tp = 2'b01;
        for (int k = 1; k <= 9; k++) begin
            cyc();
            n_checks++;
            if (dut_vec !== exp_vec()) begin
                n_fail++;
                $display("FAIL first_step_model k=%0d: got %h want %h", k, dut_vec, exp_vec());
            end
        end
        n_checks++;
        if (coil_theta !== PAT[1] || theta_pos !== 16'd1 || busy[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL first_step: coil %b pos %0d busy %b want %b 1 1",
                     coil_theta, theta_pos, busy[0], PAT[1]);
        end
    endtask

    task automatic test_fast_limit();
        tp = 2'b10;
        for (int k = 1; k <= 20; k++) begin
            cyc();
            n_checks++;
            if (dut_vec !== exp_vec()) begin
                n_fail++;
                $display("FAIL fast_model k=%0d: got %h want %h", k, dut_vec, exp_vec());
            end
        end
        n_checks++;
        if (theta_pos !== 16'(THETA_MAX) || at_limit[0] !== 1'b1 ||
            coil_theta !== PAT[THETA_MAX % NPH] || fault !== 1'b0) begin
            n_fail++;
            $display("FAIL fast_limit: pos %0d lim %b coil %b fault %b want %0d 1 %b 0",
                     theta_pos, at_limit[0], coil_theta, fault, THETA_MAX, PAT[THETA_MAX % NPH]);
        end
    endtask

    task automatic test_reversal();
        tp = 2'b00;
        cyc();
        home = 1'b1;
        cyc();
        home = 1'b0;
        n_checks++;
        if (theta_pos !== 16'd0 || dut_vec !== exp_vec()) begin
            n_fail++;
            $display("FAIL rev_home: got %h want %h", dut_vec, exp_vec());
        end
        tp = 2'b10;
        repeat (7) cyc();
        n_checks++;
        if (theta_pos !== 16'd3) begin
            n_fail++;
            $display("FAIL rev_start: pos %0d want 3", theta_pos);
        end
        tp = 2'b00;
        tn = 2'b01;
        for (int k = 1; k <= 21; k++) begin
            int want;
            cyc();
            want = (k < 13) ? 3 : (k < 21) ? 2 : 1;
            n_checks++;
            if (dut_vec !== exp_vec() || theta_pos !== 16'(want) || busy[0] !== 1'b1) begin
                n_fail++;
                $display("FAIL reversal k=%0d: pos %0d want %0d; got %h want %h",
                         k, theta_pos, want, dut_vec, exp_vec());
            end
        end
    endtask

    task automatic test_fault();
        tn = 2'b00;
        n_checks++;
        if (fault !== 1'b0) begin
            n_fail++;
            $display("FAIL fault_pre: got %b want 0", fault);
        end
        tp = 2'b01;
        tn = 2'b01;
        repeat (3) cyc();
        n_checks++;
        if (fault !== 1'b1 || theta_pos !== 16'd1 || busy[0] !== 1'b0 || dut_vec !== exp_vec()) begin
            n_fail++;
            $display("FAIL fault_conflict: got %h want %h", dut_vec, exp_vec());
        end
        tp = 2'b00;
        tn = 2'b00;
        repeat (2) cyc();
        n_checks++;
        if (fault !== 1'b1) begin
            n_fail++;
            $display("FAIL fault_sticky: got %b want 1", fault);
        end
        do_reset();
        #1;
        n_checks++;
        if (dut_vec !== 45'd0) begin
            n_fail++;
            $display("FAIL fault_reset: got %h want 0", dut_vec);
        end
        pp = 2'b11;
        cyc();
        pp = 2'b00;
        n_checks++;
        if (fault !== 1'b1 || busy !== 2'b00) begin
            n_fail++;
            $display("FAIL fault_illegal: fault %b busy %b want 1 00", fault, busy);
        end
        cyc();
        n_checks++;
        if (fault !== 1'b1 || dut_vec !== exp_vec()) begin
            n_fail++;
            $display("FAIL fault_illegal_sticky: got %h want %h", dut_vec, exp_vec());
        end
    endtask

    task automatic test_enable_home();
        do_reset();
        enable = 1'b1;
        tp = 2'b10;
        pp = 2'b10;
        repeat (9) cyc();
        n_checks++;
        if (theta_pos !== 16'd4 || phi_pos !== 16'd4 || dut_vec !== exp_vec()) begin
            n_fail++;
            $display("FAIL en_run: got %h want %h", dut_vec, exp_vec());
        end
        enable = 1'b0;
        cyc();
        n_checks++;
        if (coil_theta !== 4'b0000 || coil_phi !== 4'b0000 || busy !== 2'b00 ||
            theta_pos !== 16'd4 || phi_pos !== 16'd4) begin
            n_fail++;
            $display("FAIL en_off: got %h want coils 0 busy 0 pos 4/4", dut_vec);
        end
        tp = 2'b00;
        pp = 2'b00;
        home = 1'b1;
        cyc();
        home = 1'b0;
        n_checks++;
        if (theta_pos !== 16'd0 || phi_pos !== 16'd0 || dut_vec !== exp_vec()) begin
            n_fail++;
            $display("FAIL home: got %h want %h", dut_vec, exp_vec());
        end
        enable = 1'b1;
        cyc();
        n_checks++;
        if (coil_theta !== PAT[4 % NPH] || coil_phi !== PAT[4 % NPH] || busy !== 2'b00) begin
            n_fail++;
            $display("FAIL en_back: coils %b %b busy %b want %b", coil_theta, coil_phi, busy,
                     PAT[4 % NPH]);
        end
    endtask

    task automatic test_reset_midstep();
        tp = 2'b01;
        pp = 2'b10;
        for (int k = 1; k <= 5; k++) begin
            cyc();
            n_checks++;
            if (dut_vec !== exp_vec()) begin
                n_fail++;
                $display("FAIL midrst_model k=%0d: got %h want %h", k, dut_vec, exp_vec());
            end
        end
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        n_checks++;
        if (dut_vec !== 45'd0) begin
            n_fail++;
            $display("FAIL midrst_async: got %h want 0", dut_vec);
        end
        tp = 2'b00;
        pp = 2'b00;
        @(posedge clk);
        #3;
        rst = 1'b1;
    endtask

    function automatic logic [1:0] rnd_code();
        int r;
        r = $urandom_range(0, 15);
        if (r < 4) return 2'b00;
        if (r < 10) return 2'b01;
        if (r < 15) return 2'b10;
        return 2'b11;
    endfunction

    task automatic test_random();
        do_reset();
        enable = 1'b1;
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 7) == 0) begin
                int sel;
                sel = $urandom_range(0, 9);
                tp = (sel < 4) ? rnd_code() & 2'b10 | 2'b01 & rnd_code() : 2'b00;
                tn = (sel >= 4 && sel < 8) ? rnd_code() : 2'b00;
                if (sel == 9) tp = rnd_code();
            end
            if ($urandom_range(0, 7) == 0) begin
                pp = ($urandom_range(0, 1) == 1) ? rnd_code() : 2'b00;
                pn = (pp == 2'b00 || $urandom_range(0, 9) == 0) ? rnd_code() : 2'b00;
            end
            enable = ($urandom_range(0, 24) != 0);
            home   = ($urandom_range(0, 19) == 0);
            cyc();
            n_checks++;
            if (dut_vec !== exp_vec()) begin
                n_fail++;
                $display("FAIL random k=%0d: got %h want %h", k, dut_vec, exp_vec());
            end
        end
        home = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst    = 1'b0;
        enable = 1'b0;
        home   = 1'b0;
        tp     = 2'b00;
        tn     = 2'b00;
        pp     = 2'b00;
        pn     = 2'b00;
        model_reset();
        repeat (2) @(posedge clk);
        test_reset();
        test_first_step();
        test_fast_limit();
        test_reversal();
        test_fault();
        test_enable_home();
        test_reset_midstep();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
